// File: rtl/wb.sv
// Write-back stage: picks the value to commit (ALU, load, or link) and registers
// the register-file write enable, data and address for one cycle.
module wb #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      ctrl_wb,
  input  logic [XLEN-1:0] pc4_wb,
  input  logic [XLEN-1:0] mem_data,
  input  logic [XLEN-1:0] alu_data,
  input  logic [XLEN-1:0] rd_wb,
  output logic            op_write,
  output logic [XLEN-1:0] write_data,
  output logic [XLEN-1:0] write_addr
);

  typedef enum logic [1:0] {
    SEL_ALU  = 2'b00,
    SEL_MEM  = 2'b01,
    SEL_PC4  = 2'b10,
    SEL_RSVD = 2'b11
  } wb_sel_e;

  wb_sel_e         wb_sel;
  logic            reg_write;
  logic [REG_AW-1:0] rd_idx;
  logic            we_next;
  logic [XLEN-1:0] data_next;
  logic [XLEN-1:0] addr_next;

  assign wb_sel    = wb_sel_e'(ctrl_wb[2:1]);
  assign reg_write = ctrl_wb[0];
  assign rd_idx    = rd_wb[REG_AW-1:0];

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    data_next = '0;
    we_next   = 1'b0;
    addr_next = '0;
    case (wb_sel)
      SEL_ALU:  data_next = alu_data;
      SEL_MEM:  data_next = mem_data;
      SEL_PC4:  data_next = pc4_wb;
      default:  data_next = '0;
    endcase
    // The reserved selector and writes to x0 never reach the register file.
    we_next   = reg_write && (wb_sel != SEL_RSVD) && (rd_idx != '0);
    addr_next = {{(XLEN-REG_AW){1'b0}}, rd_idx};
  end

  // NOTE: registered state uses non-blocking assignments so all three outputs
  // update together from values sampled at the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_write   <= 1'b0;
      write_data <= '0;
      write_addr <= '0;
    end else begin
      op_write   <= we_next;
      write_data <= data_next;
      write_addr <= addr_next;
    end
  end

endmodule

// File: tb/tb_wb.sv
// Directed bench for the write-back stage: table-driven sweep plus reset,
// latency and mid-stream-reset sequences.
module tb_wb;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  ctrl_wb;
  logic [31:0] pc4_wb, mem_data, alu_data, rd_wb;
  logic        op_write;
  logic [31:0] write_data, write_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .reset(reset), .ctrl_wb(ctrl_wb), .pc4_wb(pc4_wb),
    .mem_data(mem_data), .alu_data(alu_data), .rd_wb(rd_wb),
    .op_write(op_write), .write_data(write_data), .write_addr(write_addr)
  );

  typedef struct {
    string       name;
    logic [2:0]  ctrl;
    logic [31:0] pc4, mem, alu, rd;
    logic        exp_we;
    logic [31:0] exp_data, exp_addr;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic check_out(input string name, input logic we,
                           input logic [31:0] data, input logic [31:0] addr);
    check({name, ".op_write"},   {31'b0, op_write}, {31'b0, we});
    check({name, ".write_data"}, write_data, data);
    check({name, ".write_addr"}, write_addr, addr);
  endtask

  task automatic drive(input logic [2:0] c, input logic [31:0] p,
                       input logic [31:0] m, input logic [31:0] a,
                       input logic [31:0] r);
    ctrl_wb = c; pc4_wb = p; mem_data = m; alu_data = a; rd_wb = r;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{"sel000", 3'b000, 1, 2, 3, 4, 1'b0, 32'd3, 32'd4};
    vecs[1] = '{"sel001", 3'b001, 1, 2, 3, 4, 1'b1, 32'd3, 32'd4};
    vecs[2] = '{"sel010", 3'b010, 1, 2, 3, 4, 1'b0, 32'd2, 32'd4};
    vecs[3] = '{"sel011", 3'b011, 1, 2, 3, 4, 1'b1, 32'd2, 32'd4};
    vecs[4] = '{"sel100", 3'b100, 1, 2, 3, 4, 1'b0, 32'd1, 32'd4};
    vecs[5] = '{"sel101", 3'b101, 1, 2, 3, 4, 1'b1, 32'd1, 32'd4};
    vecs[6] = '{"sel110", 3'b110, 1, 2, 3, 4, 1'b0, 32'd0, 32'd4};
    vecs[7] = '{"sel111", 3'b111, 1, 2, 3, 4, 1'b0, 32'd0, 32'd4};
    vecs[8] = '{"x0_suppress", 3'b001, 1, 2, 32'hDEADBEEF, 0,
                1'b0, 32'hDEADBEEF, 32'd0};
    vecs[9] = '{"upper_idx", 3'b011, 1, 32'h8000_0000, 3, 32'hFFFF_FFE5,
                1'b1, 32'h8000_0000, 32'd5};

    // Reset held for two edges with arbitrary inputs.
    reset = 1'b1;
    drive(3'b101, 32'h1111, 32'h2222, 32'h3333, 32'h1F);
    tick;
    check_out("reset_edge1", 1'b0, 32'd0, 32'd0);
    tick;
    check_out("reset_edge2", 1'b0, 32'd0, 32'd0);

    reset = 1'b0;
    drive(3'b001, 1, 2, 3, 4);
    tick;
    check_out("reset_release", 1'b1, 32'd3, 32'd4);

    foreach (vecs[i]) begin
      drive(vecs[i].ctrl, vecs[i].pc4, vecs[i].mem, vecs[i].alu, vecs[i].rd);
      tick;
      check_out(vecs[i].name, vecs[i].exp_we, vecs[i].exp_data, vecs[i].exp_addr);
    end

    // Input changes between edges must not reach the outputs early.
    drive(3'b001, 1, 2, 3, 4);
    tick;
    check_out("latency_before", 1'b1, 32'd3, 32'd4);
    #2 alu_data = 32'd7;
    #1;
    check_out("latency_hold", 1'b1, 32'd3, 32'd4);
    tick;
    check_out("latency_after", 1'b1, 32'd7, 32'd4);

    // Reset coinciding with a valid instruction discards it.
    drive(3'b101, 1, 2, 3, 4);
    reset = 1'b1;
    tick;
    check_out("midreset", 1'b0, 32'd0, 32'd0);
    reset = 1'b0;
    tick;
    check_out("midreset_release", 1'b1, 32'd1, 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
